// File: rtl/asi_rslv.sv
`default_nettype none
// ============================================================================
//  Module      : asi_rslv
//  Description : Read-side slave memory model for the user side of the AXI
//                slave read interface. Returns lane-masked read data a fixed
//                SLV_WS cycles after each per-beat request, flags unsupported
//                transfer sizes, and offers a byte-strobed backdoor write port
//                plus beat/burst statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module asi_rslv #(
    parameter int AXI_DW       = 128,
    parameter int AXI_AW       = 40,
    parameter int AXI_SW       = 3,
    parameter int SLV_WS       = 1,
    parameter int MEM_DEPTH    = 1024,
    parameter int SLV_MAX_SIZE = $clog2(AXI_DW / 8)
) (
    input  logic                         usr_clk,
    input  logic                         usr_reset,
    input  logic [AXI_AW-1:0]            m_raddr,
    input  logic                         m_re,
    input  logic                         m_rlast,
    input  logic [AXI_SW-1:0]            m_rsize,
    output logic [AXI_DW-1:0]            m_rdata,
    output logic                         m_rvalid,
    output logic                         m_rsize_error,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
    input  logic [AXI_DW-1:0]            bd_wdata,
    input  logic [AXI_DW/8-1:0]          bd_wstrb,
    output logic [31:0]                  beat_cnt,
    output logic [31:0]                  burst_cnt
);

    localparam int c_BYTES = AXI_DW / 8;
    localparam int c_BW    = $clog2(c_BYTES);
    localparam int c_MW    = $clog2(MEM_DEPTH);
    // Lane arithmetic needs one extra bit: alo+sz can reach c_BYTES.
    localparam int c_LW    = c_BW + 1;

    logic [AXI_DW-1:0]  r_mem [MEM_DEPTH];
    logic [c_MW-1:0]    w_idx;
    logic [AXI_DW-1:0]  w_word;
    logic [c_LW-1:0]    w_lo;
    logic [c_LW-1:0]    w_sz;
    logic [c_LW-1:0]    w_alo;
    logic [c_LW-1:0]    w_hi;
    logic [c_BYTES-1:0] w_mask;
    logic [AXI_DW-1:0]  w_beat_data;
    logic               w_size_err;
    logic [31:0]        r_beat_cnt;
    logic [31:0]        r_burst_cnt;

    // ------------------------------------------------------------------------
    // Address decode: upper address bits beyond the memory are ignored, so the
    // address space wraps modulo MEM_DEPTH words.
    // ------------------------------------------------------------------------
    assign w_idx = m_raddr[c_BW +: c_MW];

    if (c_BW > 0) begin : g_lo_wide
        assign w_lo = {1'b0, m_raddr[c_BW-1:0]};
    end else begin : g_lo_byte
        assign w_lo = '0;
    end

    if (AXI_AW > c_BW + c_MW) begin : g_addr_hi
        logic w_unused;
        assign w_unused = ^m_raddr[AXI_AW-1:c_BW+c_MW];
    end

    // ------------------------------------------------------------------------
    // Size check: combinational and independent of m_re.
    // ------------------------------------------------------------------------
    assign w_size_err    = (32'(m_rsize) > SLV_MAX_SIZE);
    assign m_rsize_error = w_size_err;

    // Beat size in bytes, clamped to the bus width, then aligned window bounds.
    always_comb begin
        w_sz = c_LW'(c_BYTES);
        if (32'(m_rsize) < c_BW) begin
            w_sz = c_LW'(1) << m_rsize;
        end
        w_alo = w_lo & ~(w_sz - c_LW'(1));
        w_hi  = w_alo + w_sz;
    end

    // Lane enable: lanes from the requested byte up to the end of the aligned
    // container. Covers narrow beats and the unaligned first beat of a burst.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < c_BYTES; i++) begin
            if ((c_LW'(i) >= w_lo) && (c_LW'(i) < w_hi)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory: read is asynchronous, so a same-cycle backdoor write to the same
    // word is seen only by later requests (read-first).
    // ------------------------------------------------------------------------
    assign w_word = r_mem[w_idx];

    for (genvar gl = 0; gl < c_BYTES; gl++) begin : g_lane
        assign w_beat_data[gl*8 +: 8] = (w_mask[gl] && !w_size_err) ? w_word[gl*8 +: 8] : 8'h00;
    end

    // Backdoor byte-strobed write; memory contents survive reset.
    always_ff @(posedge usr_clk) begin
        if (bd_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (bd_wstrb[b]) begin
                    r_mem[bd_addr][b*8 +: 8] <= bd_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Return path: either a combinational pass-through or a chain of SLV_WS
    // register stages. Reset flushes everything in flight.
    // ------------------------------------------------------------------------
    if (SLV_WS == 0) begin : g_ws0
        assign m_rvalid = m_re;
        assign m_rdata  = w_beat_data;
    end else begin : g_wsn
        logic [SLV_WS-1:0] r_vld;
        logic [AXI_DW-1:0] r_dat [SLV_WS];

        // First stage captures the masked memory word; later stages just delay.
        always_ff @(posedge usr_clk) begin
            if (usr_reset) begin
                r_vld <= '0;
                for (int s = 0; s < SLV_WS; s++) begin
                    r_dat[s] <= '0;
                end
            end else begin
                r_vld[0] <= m_re;
                r_dat[0] <= m_re ? w_beat_data : '0;
                for (int s = 1; s < SLV_WS; s++) begin
                    r_vld[s] <= r_vld[s-1];
                    r_dat[s] <= r_dat[s-1];
                end
            end
        end

        assign m_rvalid = r_vld[SLV_WS-1];
        assign m_rdata  = r_dat[SLV_WS-1];
    end

    // ------------------------------------------------------------------------
    // Statistics: every accepted beat, and every beat that closes a burst.
    // ------------------------------------------------------------------------
    always_ff @(posedge usr_clk) begin
        if (usr_reset) begin
            r_beat_cnt  <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (m_re) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
            if (m_re && m_rlast) begin
                r_burst_cnt <= r_burst_cnt + 32'd1;
            end
        end
    end

    assign beat_cnt  = r_beat_cnt;
    assign burst_cnt = r_burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_asi_rslv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asi_rslv
//  Description : Self-checking bench for asi_rslv. Three instances with 0, 1
//                and 3 wait states share one stimulus stream and are compared
//                every cycle against a behavioural memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asi_rslv;

    localparam int DW   = 128;
    localparam int AW   = 40;
    localparam int SW   = 3;
    localparam int MD   = 1024;
    localparam int MW   = 10;
    localparam int NB   = 16;
    localparam int HIST = 8192;
    localparam logic [127:0] W5 = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic          usr_clk = 1'b0;
    logic          usr_reset;
    logic [AW-1:0] m_raddr;
    logic          m_re;
    logic          m_rlast;
    logic [SW-1:0] m_rsize;
    logic          bd_we;
    logic [MW-1:0] bd_addr;
    logic [DW-1:0] bd_wdata;
    logic [NB-1:0] bd_wstrb;

    logic [DW-1:0] rdata0, rdata1, rdata3;
    logic          rvalid0, rvalid1, rvalid3;
    logic          serr0, serr1, serr3;
    logic [31:0]   beat0, beat1, beat3;
    logic [31:0]   burst0, burst1, burst3;

    int checks = 0;
    int errors = 0;

    always #5 usr_clk = ~usr_clk;

    asi_rslv #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .SLV_WS(0), .MEM_DEPTH(MD)) u0 (
        .usr_clk(usr_clk), .usr_reset(usr_reset), .m_raddr(m_raddr), .m_re(m_re),
        .m_rlast(m_rlast), .m_rsize(m_rsize), .m_rdata(rdata0), .m_rvalid(rvalid0),
        .m_rsize_error(serr0), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_wstrb(bd_wstrb), .beat_cnt(beat0), .burst_cnt(burst0));

    asi_rslv #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .SLV_WS(1), .MEM_DEPTH(MD)) u1 (
        .usr_clk(usr_clk), .usr_reset(usr_reset), .m_raddr(m_raddr), .m_re(m_re),
        .m_rlast(m_rlast), .m_rsize(m_rsize), .m_rdata(rdata1), .m_rvalid(rvalid1),
        .m_rsize_error(serr1), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_wstrb(bd_wstrb), .beat_cnt(beat1), .burst_cnt(burst1));

    asi_rslv #(.AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW), .SLV_WS(3), .MEM_DEPTH(MD)) u3 (
        .usr_clk(usr_clk), .usr_reset(usr_reset), .m_raddr(m_raddr), .m_re(m_re),
        .m_rlast(m_rlast), .m_rsize(m_rsize), .m_rdata(rdata3), .m_rvalid(rvalid3),
        .m_rsize_error(serr3), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_wstrb(bd_wstrb), .beat_cnt(beat3), .burst_cnt(burst3));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Known preload pattern; word 5 carries the reference word.
    function automatic logic [127:0] pre(input int w);
        if (w == 5) return W5;
        return {4{32'h9E3779B9 * 32'(w + 1)}} ^ {16{8'(w * 17)}};
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural reference: a word array, a per-cycle history of requests and
    // resets, and plain counts. A beat requested in cycle c appears in cycle
    // c+L unless a reset is applied in any of cycles c .. c+L-1.
    // ------------------------------------------------------------------------
    logic [127:0] mm [MD];
    bit           re_h  [HIST];
    bit           rst_h [HIST];
    logic [127:0] dat_h [HIST];
    int           k = 0;
    bit           armed = 0;
    int unsigned  mbeat = 0;
    int unsigned  mburst = 0;

    function automatic logic [127:0] model_read(input logic [39:0] a, input logic [2:0] sz);
        int n, lo, alo;
        logic [127:0] w, r;
        if (sz > 3'd4) return '0;
        n   = 1 << sz;
        lo  = int'(a[3:0]);
        alo = (lo / n) * n;
        w   = mm[a[13:4]];
        r   = '0;
        for (int i = 0; i < 16; i++)
            if (i >= lo && i < alo + n) r[i*8 +: 8] = w[i*8 +: 8];
        return r;
    endfunction

    function automatic bit exp_valid(input int L);
        int c;
        c = k - L;
        if (c < 0) return 1'b0;
        if (!re_h[c]) return 1'b0;
        for (int j = c; j < c + L; j++)
            if (rst_h[j]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_inst(input string nm, input int L, input logic v, input logic [127:0] d);
        bit ev;
        ev = exp_valid(L);
        chk({nm, " rvalid"}, 128'(v), 128'(ev));
        if (ev) chk({nm, " rdata"}, d, dat_h[k - L]);
    endtask

    initial begin
        forever begin
            @(negedge usr_clk);
            if (k < HIST) begin
                re_h[k]  = m_re;
                rst_h[k] = usr_reset;
                dat_h[k] = model_read(m_raddr, m_rsize);
                if (armed) begin
                    check_inst("u0", 0, rvalid0, rdata0);
                    check_inst("u1", 1, rvalid1, rdata1);
                    check_inst("u3", 3, rvalid3, rdata3);
                    chk("u0 size_error", 128'(serr0), 128'(m_rsize > 3'd4));
                    chk("u1 size_error", 128'(serr1), 128'(m_rsize > 3'd4));
                    chk("u3 size_error", 128'(serr3), 128'(m_rsize > 3'd4));
                    chk("u0 beat_cnt", 128'(beat0), 128'(mbeat));
                    chk("u3 beat_cnt", 128'(beat3), 128'(mbeat));
                    chk("u1 burst_cnt", 128'(burst1), 128'(mburst));
                    chk("u3 burst_cnt", 128'(burst3), 128'(mburst));
                end
                if (usr_reset) begin
                    mbeat  = 0;
                    mburst = 0;
                    armed  = 1'b1;
                end else if (armed) begin
                    if (m_re) mbeat++;
                    if (m_re && m_rlast) mburst++;
                end
                if (bd_we)
                    for (int b = 0; b < NB; b++)
                        if (bd_wstrb[b]) mm[bd_addr][b*8 +: 8] = bd_wdata[b*8 +: 8];
                k++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic bd_write(input int w, input logic [127:0] d, input logic [15:0] s);
        @(posedge usr_clk); #1;
        bd_we = 1'b1; bd_addr = MW'(w); bd_wdata = d; bd_wstrb = s;
        @(posedge usr_clk); #1;
        bd_we = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge usr_clk); #1;
        usr_reset = 1'b1;
        @(posedge usr_clk); #1;
        usr_reset = 1'b0;
    endtask

    task automatic read_once(input logic [39:0] a, input logic [2:0] s,
                             output logic [127:0] d0, output logic v0, output logic e0,
                             output logic [127:0] d1, output logic v1,
                             output logic [127:0] d3, output logic v3);
        @(posedge usr_clk); #1;
        m_re = 1'b1; m_raddr = a; m_rsize = s; m_rlast = 1'b1;
        @(negedge usr_clk);
        d0 = rdata0; v0 = rvalid0; e0 = serr0;
        @(posedge usr_clk); #1;
        m_re = 1'b0; m_rlast = 1'b0;
        @(negedge usr_clk);
        d1 = rdata1; v1 = rvalid1;
        @(negedge usr_clk);
        @(negedge usr_clk);
        d3 = rdata3; v3 = rvalid3;
    endtask

    typedef struct {
        logic [39:0]  addr;
        logic [2:0]   size;
        logic [127:0] exp;
        logic         err;
    } vec_t;

    vec_t tv [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] d0, d1, d3, da, db, dc, dd, de;
        logic         v0, v1, v3, e0;
        logic         bv [9];
        logic [127:0] bdat [9];

        tv[0] = '{40'h50,         3'd4, W5, 1'b0};
        tv[1] = '{40'h53,         3'd0, 128'h0000_0000_0000_0000_0000_0000_CC00_0000, 1'b0};
        tv[2] = '{40'h53,         3'd2, 128'h0000_0000_0000_0000_0000_0000_CC00_0000, 1'b0};
        tv[3] = '{40'h50,         3'd5, 128'h0, 1'b1};
        tv[4] = '{40'h4050,       3'd4, W5, 1'b0};
        tv[5] = '{40'h58,         3'd3, 128'h0011_2233_4455_6677_0000_0000_0000_0000, 1'b0};
        tv[6] = '{40'h55,         3'd1, 128'h0000_0000_0000_0000_0000_AA00_0000_0000, 1'b0};
        tv[7] = '{40'h53,         3'd4, 128'h0011_2233_4455_6677_8899_AABB_CC00_0000, 1'b0};
        tv[8] = '{40'h5F,         3'd7, 128'h0, 1'b1};
        tv[9] = '{40'h80_0000_0050, 3'd2, 128'h0000_0000_0000_0000_0000_0000_CCDD_EEFF, 1'b0};

        usr_reset = 1'b1; m_raddr = '0; m_re = 1'b0; m_rlast = 1'b0; m_rsize = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0; bd_wstrb = '0;
        repeat (3) @(posedge usr_clk);
        #1 usr_reset = 1'b0;

        @(negedge usr_clk);
        chk("reset rvalid u3", 128'(rvalid3), 128'h0);
        chk("reset rdata u1", rdata1, 128'h0);
        chk("reset beat_cnt", 128'(beat1), 128'h0);
        chk("reset burst_cnt", 128'(burst0), 128'h0);

        for (int w = 0; w < 16; w++) bd_write(w, pre(w), 16'hFFFF);

        // Directed vector table: each read is checked on all three latencies.
        for (int i = 0; i < 10; i++) begin
            read_once(tv[i].addr, tv[i].size, d0, v0, e0, d1, v1, d3, v3);
            chk($sformatf("vec%0d size_error", i), 128'(e0), 128'(tv[i].err));
            chk($sformatf("vec%0d u0 valid", i), 128'(v0), 128'h1);
            chk($sformatf("vec%0d u0 data", i), d0, tv[i].exp);
            chk($sformatf("vec%0d u1 valid", i), 128'(v1), 128'h1);
            chk($sformatf("vec%0d u1 data", i), d1, tv[i].exp);
            chk($sformatf("vec%0d u3 valid", i), 128'(v3), 128'h1);
            chk($sformatf("vec%0d u3 data", i), d3, tv[i].exp);
        end
        chk("table beat_cnt", 128'(beat1), 128'd10);
        chk("table burst_cnt", 128'(burst3), 128'd10);

        // Burst of four back-to-back beats: four consecutive valids, in order.
        pulse_reset();
        for (int t = 0; t < 9; t++) begin
            @(posedge usr_clk); #1;
            if (t < 4) begin
                m_re = 1'b1; m_raddr = 40'(t * 16); m_rsize = 3'd4; m_rlast = (t == 3);
            end else begin
                m_re = 1'b0; m_rlast = 1'b0;
            end
            @(negedge usr_clk);
            bv[t] = rvalid3; bdat[t] = rdata3;
        end
        for (int t = 0; t < 9; t++) begin
            chk($sformatf("burst u3 valid t%0d", t), 128'(bv[t]), 128'((t >= 3) && (t <= 6)));
            if (t >= 3 && t <= 6) chk($sformatf("burst u3 data t%0d", t), bdat[t], pre(t - 3));
        end
        chk("burst beat_cnt", 128'(beat3), 128'd4);
        chk("burst burst_cnt", 128'(burst3), 128'd1);

        // Backdoor collision (read-first) and address wrap onto word 7.
        @(posedge usr_clk); #1;
        bd_we = 1'b1; bd_addr = 10'd7; bd_wdata = {16{8'hA5}}; bd_wstrb = 16'hFFFF;
        m_re = 1'b1; m_raddr = 40'h70; m_rsize = 3'd4; m_rlast = 1'b1;
        @(negedge usr_clk);
        da = rdata0;
        @(posedge usr_clk); #1;
        bd_we = 1'b0;
        @(negedge usr_clk);
        db = rdata1; dc = rdata0;
        @(posedge usr_clk); #1;
        m_raddr = 40'h4070;
        @(negedge usr_clk);
        dd = rdata1;
        @(posedge usr_clk); #1;
        m_re = 1'b0; m_rlast = 1'b0;
        @(negedge usr_clk);
        de = rdata1;
        chk("collision u0 old", da, pre(7));
        chk("collision u1 old", db, pre(7));
        chk("reread u0 new", dc, {16{8'hA5}});
        chk("reread u1 new", dd, {16{8'hA5}});
        chk("wrap 0x4070 u1", de, {16{8'hA5}});

        // Reset with two beats in flight on the 3-wait-state instance.
        pulse_reset();
        for (int t = 0; t < 8; t++) begin
            @(posedge usr_clk); #1;
            m_re = (t < 2); m_raddr = 40'(16 + t * 16); m_rsize = 3'd4; m_rlast = (t == 1);
            usr_reset = (t == 2);
            @(negedge usr_clk);
            if (t >= 2) chk($sformatf("flush u3 valid t%0d", t), 128'(rvalid3), 128'h0);
            if (t == 3) begin
                chk("flush beat_cnt", 128'(beat3), 128'h0);
                chk("flush burst_cnt", 128'(burst3), 128'h0);
            end
        end
        read_once(40'h50, 3'd4, d0, v0, e0, d1, v1, d3, v3);
        chk("post-reset u3 valid", 128'(v3), 128'h1);
        chk("post-reset u3 data", d3, W5);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge usr_clk); #1;
            m_re      = ($urandom_range(0, 3) != 0);
            m_raddr   = (40'($urandom) << 14) | (40'($urandom_range(0, 15)) << 4) | 40'($urandom_range(0, 15));
            m_rsize   = 3'($urandom_range(0, 7));
            m_rlast   = 1'($urandom_range(0, 1));
            bd_we     = ($urandom_range(0, 2) == 0);
            bd_addr   = 10'($urandom_range(0, 15));
            bd_wdata  = {$urandom, $urandom, $urandom, $urandom};
            bd_wstrb  = 16'($urandom);
            usr_reset = ($urandom_range(0, 99) == 0);
        end
        @(posedge usr_clk); #1;
        m_re = 1'b0; m_rlast = 1'b0; bd_we = 1'b0; usr_reset = 1'b0;
        repeat (6) @(negedge usr_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
